// File: rtl/sys_ctrl.sv
// rtl/sys_ctrl.sv - command sequencer between the UART RX/TX path, register file and ALU.
// Every output is a register loaded from the next-state logic, so strobes never glitch.
module sys_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ALU_OUT_W  = 2 * DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
  input  logic                  RF_RD_DATA_VLD,
  input  logic [ALU_OUT_W-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  input  logic                  FIFO_FULL,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic                  RF_WR_EN,
  output logic                  RF_RD_EN,
  output logic [DATA_WIDTH-1:0] RF_WR_DATA,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic                  CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  ERR_CMD
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FN, ALU_WAIT,
    TX_RD, TX_LO, TX_HI
  } state_t;

  state_t                  state, state_n;
  logic [DATA_WIDTH-1:0]   rd_data, rd_data_n;
  logic [ALU_OUT_W-1:0]    result, result_n;
  logic [ADDR_WIDTH-1:0]   rf_addr_n;
  logic                    rf_wr_en_n, rf_rd_en_n, alu_en_n, gate_n, tx_vld_n, err_n;
  logic [DATA_WIDTH-1:0]   rf_wr_data_n, tx_data_n;
  logic [3:0]              alu_fun_n;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      rd_data     <= '0;
      result      <= '0;
      RF_ADDR     <= '0;
      RF_WR_EN    <= 1'b0;
      RF_RD_EN    <= 1'b0;
      RF_WR_DATA  <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
      ERR_CMD     <= 1'b0;
    end else begin
      state       <= state_n;
      rd_data     <= rd_data_n;
      result      <= result_n;
      RF_ADDR     <= rf_addr_n;
      RF_WR_EN    <= rf_wr_en_n;
      RF_RD_EN    <= rf_rd_en_n;
      RF_WR_DATA  <= rf_wr_data_n;
      ALU_EN      <= alu_en_n;
      ALU_FUN     <= alu_fun_n;
      CLK_GATE_EN <= gate_n;
      TX_P_DATA   <= tx_data_n;
      TX_D_VLD    <= tx_vld_n;
      ERR_CMD     <= err_n;
    end
  end

  // Data outputs hold their last value; strobes default low so each lasts one cycle.
  always_comb begin
    state_n      = state;
    rd_data_n    = rd_data;
    result_n     = result;
    rf_addr_n    = RF_ADDR;
    rf_wr_en_n   = 1'b0;
    rf_rd_en_n   = 1'b0;
    rf_wr_data_n = RF_WR_DATA;
    alu_en_n     = 1'b0;
    alu_fun_n    = ALU_FUN;
    gate_n       = CLK_GATE_EN;
    tx_data_n    = TX_P_DATA;
    tx_vld_n     = 1'b0;
    err_n        = 1'b0;
    case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            CMD_WR:     state_n = WR_ADDR;
            CMD_RD:     state_n = RD_ADDR;
            CMD_ALU_OP: begin
              state_n = ALU_A;
              gate_n  = 1'b1;
            end
            CMD_ALU_NO: begin
              state_n = ALU_FN;
              gate_n  = 1'b1;
            end
            default:    err_n = 1'b1;
          endcase
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          rf_addr_n = RX_P_DATA[ADDR_WIDTH-1:0];
          state_n   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          rf_wr_en_n   = 1'b1;
          rf_wr_data_n = RX_P_DATA;
          state_n      = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          rf_addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
          rf_rd_en_n = 1'b1;
          state_n    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (RF_RD_DATA_VLD) begin
          rd_data_n = RF_RD_DATA;
          state_n   = TX_RD;
        end
      end
      // Operands land at fixed register-file locations 0 and 1 where the ALU reads them.
      ALU_A: begin
        if (RX_D_VLD) begin
          rf_wr_en_n   = 1'b1;
          rf_addr_n    = '0;
          rf_wr_data_n = RX_P_DATA;
          state_n      = ALU_B;
        end
      end
      ALU_B: begin
        if (RX_D_VLD) begin
          rf_wr_en_n   = 1'b1;
          rf_addr_n    = ADDR_WIDTH'(1);
          rf_wr_data_n = RX_P_DATA;
          state_n      = ALU_FN;
        end
      end
      ALU_FN: begin
        if (RX_D_VLD) begin
          alu_en_n  = 1'b1;
          alu_fun_n = RX_P_DATA[3:0];
          state_n   = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          result_n = ALU_OUT;
          state_n  = TX_LO;
        end
      end
      TX_RD: begin
        if (!FIFO_FULL) begin
          tx_vld_n  = 1'b1;
          tx_data_n = rd_data;
          state_n   = IDLE;
        end
      end
      TX_LO: begin
        if (!FIFO_FULL) begin
          tx_vld_n  = 1'b1;
          tx_data_n = result[DATA_WIDTH-1:0];
          state_n   = TX_HI;
        end
      end
      TX_HI: begin
        if (!FIFO_FULL) begin
          tx_vld_n  = 1'b1;
          tx_data_n = result[ALU_OUT_W-1:DATA_WIDTH];
          gate_n    = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
